fetch_decode_stage: RTL and testbench
=====================================

Name: fetch_decode_stage

Overview:
- IF/ID pipeline stage that consumes `prgCount` from the program counter register and drives that register's redirect controls: `j`, `br`, `jAdx`, `brAdx`.
- Latches the instruction word read at `prgCount` and decodes jump/branch opcodes in ID.
- Squashes the wrong-path instruction after a taken redirect and counts issued and squashed slots.
- Sits between instruction memory and the register file / execute stage.

Parameters:
- `PC_W`, 7, width of `prgCount` / `pc_out`.
- `CNT_W`, 8, width of the saturating statistics counters.
- `OP_J`, 6'b000010, opcode of unconditional jump.
- `OP_BNE`, 6'b000101, opcode of branch-if-not-equal (taken when `z`=0).

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `prgCount`  in  `PC_W`  current fetch address from the program counter register.
- `instr_in`  in  32  instruction memory read data for `prgCount`, combinational.
- `z`  in  1  register-compare zero flag for the ID instruction (1 = rs==rt).
- `j`  out  1  jump request to the PC register.
- `br`  out  1  branch request to the PC register (PC applies `br & ~z`).
- `jAdx`  out  26  jump target field.
- `brAdx`  out  32  branch offset, added to `prgCount+1` by the PC register.
- `instr_out`  out  32  IF/ID instruction register.
- `pc_out`  out  `PC_W`  address of `instr_out`.
- `valid_out`  out  1  `instr_out` is a real (non-squashed) instruction.
- `rs_out`  out  5  `instr_out[25:21]`.
- `rt_out`  out  5  `instr_out[20:16]`.
- `issue_cnt`  out  `CNT_W`  valid instructions presented in ID, saturating.
- `squash_cnt`  out  `CNT_W`  squashed slots, saturating.

Behaviour:
- Reset (synchronous; wins over all other activity, including mid-redirect): `instr_out`=0, `pc_out`=0, `valid_out`=0, both counters 0. All outputs therefore read 0.
- Decode is combinational from the IF/ID register:
  - `is_j` = (`instr_out[31:26]`==`OP_J`).
  - `is_b` = (`instr_out[31:26]`==`OP_BNE`).
  - `j` = `valid_out & is_j`.
  - `br` = `valid_out & is_b`.
  - `jAdx` = `instr_out[25:0]`, driven regardless of `valid_out`.
  - `brAdx` = sign-extend(`instr_out[15:0]`) − 1 in 32-bit two's complement. Since `prgCount` = `pc_out`+1 when the branch is in ID, the target is `pc_out`+1+imm (MIPS semantics). Wrap is modulo 2^32; the PC keeps the low 7 bits.
- `redirect` = `j | (br & ~z)`.
- Every non-reset edge:
  - `instr_out` <= `instr_in`; `pc_out` <= `prgCount`.
  - `valid_out` <= ~`redirect`. The delay-slot instruction fetched during a redirect is squashed; its bits are still loaded.
- State is implicit in `valid_out`:
  - RUN (`valid_out`=1) -> SQUASH (`valid_out`=0) on `redirect`.
  - SQUASH -> RUN unconditionally.
  - A squashed jump/branch never redirects, so there are no back-to-back redirects.
- First cycle after reset release is SQUASH (`valid_out`=0). This lets PC 0 be fetched and reach ID one cycle later.
- Latency: instruction at PC n is visible in ID one edge after `prgCount`=n. Redirect takes effect at the PC on the same edge; the target appears in ID two edges after the redirecting instruction entered ID.
- Counters: `issue_cnt` +1 on each edge where `valid_out`=1 before the edge. `squash_cnt` +1 on each edge where `valid_out` is loaded 0 due to `redirect`. Both saturate at 2^`CNT_W`−1 and do not wrap.
- `z` is ignored unless `br`=1. `j` and `br` are mutually exclusive by decode.

Decomposition:
- Shared package `cpu_pkg`: `OP_J`, `OP_BNE`, opcode/field bit positions, `PC_W`, NOP constant (32'h0).
- One natural sub-module, `sat_counter` (width param, inc, reset). It is instantiated twice, for `issue_cnt` and `squash_cnt`.
- Bench pairs the block with the existing PC register and a 128-word ROM model.

Test Plan:
- Reset held 2 cycles, ROM = NOPs -> all outputs 0. After release `valid_out` goes 0 then 1, `pc_out` steps 0,1,2…, `issue_cnt` increments each cycle.
- J at PC 3 with `jAdx`=15:
  - ID shows PC 3 with `j`=1.
  - Next ID slot (PC 4) has `valid_out`=0 and `squash_cnt`=1.
  - Following slot `pc_out`=15.
- BNE at PC 5, imm=+4, `z`=0 -> `brAdx`=3, slot PC 6 squashed, next `pc_out`=10.
- Same BNE with `z`=1 -> `br`=1, no redirect, PC 6 valid, `squash_cnt` unchanged.
- BNE at PC 20, imm=−5 (`brAdx`=32'hFFFFFFFA) -> next valid `pc_out`=16.
- Reset asserted in the cycle a J is in ID -> outputs 0 next edge, `prgCount` 0, no squash counted. Separately, 300 straight-line cycles -> `issue_cnt` saturates at 255.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcodes, instruction field positions, widths and the
// branch-offset helper used by the IF/ID stage.
package cpu_pkg;
  localparam int PC_W  = 7;
  localparam int CNT_W = 8;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BNE = 6'b000101;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

  localparam logic [31:0] NOP = 32'h0;

  // PC register adds this to prgCount+1, and prgCount is already pc_out+1
  // while the branch sits in ID, hence the -1.
  function automatic logic [31:0] brOffset(input logic [15:0] imm);
    return {{16{imm[15]}}, imm} - 32'd1;
  endfunction
endpackage

// File: rtl/fetch_decode_stage_if.sv
// Bus between the IF/ID stage and its neighbours: PC register, instruction
// memory and the register file / execute stage.
interface fetch_decode_stage_if;
  logic [cpu_pkg::PC_W-1:0]  prgCount;
  logic [31:0]               instr_in;
  logic                      z;
  logic                      j;
  logic                      br;
  logic [25:0]               jAdx;
  logic [31:0]               brAdx;
  logic [31:0]               instr_out;
  logic [cpu_pkg::PC_W-1:0]  pc_out;
  logic                      valid_out;
  logic [4:0]                rs_out;
  logic [4:0]                rt_out;
  logic [cpu_pkg::CNT_W-1:0] issue_cnt;
  logic [cpu_pkg::CNT_W-1:0] squash_cnt;

  modport master (
    input  prgCount, instr_in, z,
    output j, br, jAdx, brAdx, instr_out, pc_out, valid_out, rs_out, rt_out,
           issue_cnt, squash_cnt
  );
  modport slave (
    output prgCount, instr_in, z,
    input  j, br, jAdx, brAdx, instr_out, pc_out, valid_out, rs_out, rt_out,
           issue_cnt, squash_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk) begin
    if (reset)                          count <= '0;
    else if (inc && count != {W{1'b1}}) count <= count + 1'b1;
  end
endmodule

// File: rtl/fetch_decode_stage.sv
// IF/ID register with jump/branch decode, one-slot squash after a taken
// redirect, and issue/squash statistics.
module fetch_decode_stage
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  fetch_decode_stage_if.master bus
);
  logic isJ, isB, redirect;

  assign isJ = bus.instr_out[OP_HI:OP_LO] == OP_J;
  assign isB = bus.instr_out[OP_HI:OP_LO] == OP_BNE;

  assign bus.j      = bus.valid_out & isJ;
  assign bus.br     = bus.valid_out & isB;
  assign bus.jAdx   = bus.instr_out[RS_HI:0];
  assign bus.brAdx  = brOffset(bus.instr_out[15:0]);
  assign bus.rs_out = bus.instr_out[RS_HI:RS_LO];
  assign bus.rt_out = bus.instr_out[RT_HI:RT_LO];

  // A squashed slot never decodes as j/br, so redirects cannot chain.
  assign redirect = bus.j | (bus.br & ~bus.z);

  // Delay-slot bits still load on a redirect; only valid_out drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.instr_out <= NOP;
      bus.pc_out    <= '0;
      bus.valid_out <= 1'b0;
    end else begin
      bus.instr_out <= bus.instr_in;
      bus.pc_out    <= bus.prgCount;
      bus.valid_out <= ~redirect;
    end
  end

  sat_counter #(.W(CNT_W)) uIssue (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.valid_out),
    .count (bus.issue_cnt)
  );

  sat_counter #(.W(CNT_W)) uSquash (
    .clk   (clk),
    .reset (reset),
    .inc   (redirect),
    .count (bus.squash_cnt)
  );
endmodule

// File: tb/tb_fetch_decode_stage.sv
// Bench: IF/ID stage paired with a PC register model and a 128-word ROM;
// expected ID-slot contents are queued per phase and popped each cycle.
module tb_fetch_decode_stage;
  import cpu_pkg::*;

  typedef struct {
    int          pc;
    bit          vld;
    bit          j;
    bit          br;
    int          iss;
    int          sq;
    logic [31:0] instr;
    logic [31:0] adx;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  pc;
  logic [31:0] rom [128];
  exp_t        sbq [$];
  int          nChk = 0;
  int          nErr = 0;

  always #5 clk = ~clk;

  fetch_decode_stage_if bus ();

  fetch_decode_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // PC register: applies the stage's redirect controls on the same edge.
  always @(posedge clk) begin
    if (reset)                   pc <= 7'd0;
    else if (bus.j)              pc <= bus.jAdx[6:0];
    else if (bus.br & ~bus.z)    pc <= pc + 7'd1 + bus.brAdx[6:0];
    else                         pc <= pc + 7'd1;
  end

  assign bus.prgCount = pc;
  assign bus.instr_in = rom[pc];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nChk++;
    if (obs !== expv) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic push(input int p, input bit v, input bit jj, input bit bb,
                      input int iss, input int sq, input logic [31:0] adx = 32'h0);
    exp_t e;
    e.pc = p; e.vld = v; e.j = jj; e.br = bb; e.iss = iss; e.sq = sq;
    e.instr = rom[p]; e.adx = adx;
    sbq.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("pc_out",     32'(bus.pc_out),     32'(e.pc));
      chk("valid_out",  32'(bus.valid_out),  32'(e.vld));
      chk("j",          32'(bus.j),          32'(e.j));
      chk("br",         32'(bus.br),         32'(e.br));
      chk("issue_cnt",  32'(bus.issue_cnt),  32'(e.iss));
      chk("squash_cnt", 32'(bus.squash_cnt), 32'(e.sq));
      chk("instr_out",  bus.instr_out,       e.instr);
      chk("rs_out",     32'(bus.rs_out),     32'(e.instr[25:21]));
      chk("rt_out",     32'(bus.rt_out),     32'(e.instr[20:16]));
      if (e.j)  chk("jAdx",  32'(bus.jAdx), e.adx);
      if (e.br) chk("brAdx", bus.brAdx,     e.adx);
    end
  end

  task automatic loadNop();
    for (int i = 0; i < 128; i++) rom[i] = NOP;
  endtask

  // Leaves at a negedge with reset still high after two rising edges.
  task automatic holdReset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  initial begin
    bus.z = 1'b0;
    loadNop();

    // Straight-line NOPs, reset state first
    holdReset();
    chk("rst instr_out",  bus.instr_out,          32'h0);
    chk("rst pc_out",     32'(bus.pc_out),        32'h0);
    chk("rst valid_out",  32'(bus.valid_out),     32'h0);
    chk("rst j",          32'(bus.j),             32'h0);
    chk("rst br",         32'(bus.br),            32'h0);
    chk("rst jAdx",       32'(bus.jAdx),          32'h0);
    chk("rst rs_out",     32'(bus.rs_out),        32'h0);
    chk("rst issue_cnt",  32'(bus.issue_cnt),     32'h0);
    chk("rst squash_cnt", 32'(bus.squash_cnt),    32'h0);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) push(k, 1, 0, 0, k, 0);
    drain();

    // J at PC 3 -> 15
    holdReset();
    rom[3] = {OP_J, 26'd15};
    reset = 1'b0;
    for (int k = 0; k < 3; k++) push(k, 1, 0, 0, k, 0);
    push(3,  1, 1, 0, 3, 0, 32'd15);
    push(4,  0, 0, 0, 4, 1);
    push(15, 1, 0, 0, 4, 1);
    push(16, 1, 0, 0, 5, 1);
    drain();

    // BNE at PC 5, imm +4, taken
    holdReset();
    loadNop();
    rom[5] = {OP_BNE, 5'd1, 5'd2, 16'd4};
    bus.z = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) push(k, 1, 0, 0, k, 0);
    push(5,  1, 0, 1, 5, 0, 32'd3);
    push(6,  0, 0, 0, 6, 1);
    push(10, 1, 0, 0, 6, 1);
    push(11, 1, 0, 0, 7, 1);
    drain();

    // Same BNE, z=1: not taken
    holdReset();
    bus.z = 1'b1;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) push(k, 1, 0, 0, k, 0);
    push(5, 1, 0, 1, 5, 0, 32'd3);
    push(6, 1, 0, 0, 6, 0);
    push(7, 1, 0, 0, 7, 0);
    drain();

    // Backward BNE at PC 20, imm -5
    holdReset();
    loadNop();
    rom[20] = {OP_BNE, 5'd1, 5'd2, 16'hFFFB};
    bus.z = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < 20; k++) push(k, 1, 0, 0, k, 0);
    push(20, 1, 0, 1, 20, 0, 32'hFFFF_FFFA);
    push(21, 0, 0, 0, 21, 1);
    push(16, 1, 0, 0, 21, 1);
    push(17, 1, 0, 0, 22, 1);
    drain();

    // Reset while a J sits in ID
    holdReset();
    loadNop();
    rom[3] = {OP_J, 26'd15};
    reset = 1'b0;
    for (int k = 0; k < 3; k++) push(k, 1, 0, 0, k, 0);
    push(3, 1, 1, 0, 3, 0, 32'd15);
    repeat (4) @(negedge clk);
    chk("mid j before reset", 32'(bus.j), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #2;
    chk("midrst pc_out",     32'(bus.pc_out),     32'h0);
    chk("midrst valid_out",  32'(bus.valid_out),  32'h0);
    chk("midrst instr_out",  bus.instr_out,       32'h0);
    chk("midrst j",          32'(bus.j),          32'h0);
    chk("midrst prgCount",   32'(bus.prgCount),   32'h0);
    chk("midrst squash_cnt", 32'(bus.squash_cnt), 32'h0);
    chk("midrst issue_cnt",  32'(bus.issue_cnt),  32'h0);
    drain();

    // Long straight-line run: issue counter saturates
    holdReset();
    loadNop();
    reset = 1'b0;
    repeat (300) @(negedge clk);
    chk("sat issue_cnt",  32'(bus.issue_cnt),  32'd255);
    chk("sat squash_cnt", 32'(bus.squash_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChk, nErr);
    $finish;
  end
endmodule
